rom_alu_sequencer: RTL and testbench
====================================

ROM_ALU_SEQUENCER -- requirements
Module: rom_alu_sequencer

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 50_000_000, meaning cycles each result is held on display (legal range 1..2^26-1).
REQ-002 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port start_addr  in  8  first ROM address of a sequence.
REQ-005 SHALL have port end_addr  in  8  last ROM address of a sequence.
REQ-006 SHALL have port run  in  1  level; high = free-running auto mode.
REQ-007 SHALL have port step  in  1  single-cycle pulse (already debounced); executes one address.
REQ-008 SHALL have port addr_o  out  8  address driven onto the address-latch input of the ROM/ALU stage.
REQ-009 SHALL have ports en_a, en_b, en_c  out  1 each  load strobes for the address register, the ROM word register and the result register.
REQ-010 SHALL have ports busy  out  1 (not in IDLE) and done  out  1 (one-cycle completion pulse).

Function
REQ-011 SHALL implement states IDLE, SET_ADDR, WAIT_ROM, LOAD_WORD, LOAD_RES, DWELL, NEXT.
REQ-012 In IDLE, run=1 SHALL capture start_addr and end_addr into internal registers, set cur=start_addr and go to SET_ADDR.
REQ-013 In IDLE with run=0, step=1 SHALL execute only cur (no capture), then return to IDLE with cur advanced.
REQ-014 run and step both high in IDLE SHALL behave as run (run has priority).
REQ-015 step while busy=1 SHALL be ignored (not queued).
REQ-016 SET_ADDR SHALL last 1 cycle with en_a=1 and addr_o=cur.
REQ-017 WAIT_ROM SHALL last 1 cycle, all strobes low (synchronous ROM read latency).
REQ-018 LOAD_WORD SHALL last 1 cycle with en_b=1.
REQ-019 LOAD_RES SHALL last 1 cycle with en_c=1 (ALU is combinational from the loaded word).
REQ-020 Strobes SHALL be one-hot or all-zero, registered outputs, never high outside their state.
REQ-021 DWELL SHALL last exactly DWELL_CYCLES cycles, then go to NEXT.
REQ-022 Step-mode latency step-edge to en_c SHALL be 4 cycles; total step execution = 4 + DWELL_CYCLES + 1 cycles.
REQ-023 NEXT (1 cycle): if cur==end_addr, done=1, cur=start_addr (captured); else cur=cur+1 modulo 256.
REQ-024 NEXT in run mode: run=1 -> SET_ADDR; run=0 -> IDLE.
REQ-025 Deasserting run mid-sequence SHALL complete the current address through DWELL before IDLE.
REQ-026 end_addr<start_addr SHALL wrap 8'hFF -> 8'h00 and continue to end_addr.
REQ-027 start_addr==end_addr SHALL execute that single address repeatedly while run=1, done pulsing each pass.
REQ-028 addr_o SHALL hold cur between SET_ADDR cycles.

Reset
REQ-029 rst=1 at any clock edge SHALL force IDLE, cur=0, captured registers=0, addr_o=0, en_a=en_b=en_c=0, busy=0, done=0, dwell counter=0.
REQ-030 Reset mid-operation SHALL abort immediately; no strobe asserts in the cycle after rst sampled high.
REQ-031 rst SHALL take priority over run and step.

Structure
REQ-032 Shared package seq_pkg SHALL hold the state enum type, ADDR_W=8 and the strobe-vector typedef.
REQ-033 Dwell timing SHALL be one sub-module, dwell_timer (load/start, terminal-count pulse), parameterised by DWELL_CYCLES.
REQ-034 FSM, address counter and captured range registers SHALL reside in rom_alu_sequencer.

Verification (DWELL_CYCLES=4)
REQ-035 Reset: rst=1 during SET_ADDR -> next cycle state IDLE, all outputs 0.
REQ-036 Step: cur=0, step pulse at cycle 0 -> en_a cycle 1 (addr_o=0), en_b cycle 3, en_c cycle 4, IDLE at cycle 10, cur=1.
REQ-037 Run: start=8'h10, end=8'h12, run held -> en_a with addr_o 10,11,12,10,...; done pulses once per pass in NEXT after 12; period 9 cycles/address.
REQ-038 Wrap: start=8'hFE, end=8'h01 -> addr_o sequence FE,FF,00,01,FE.
REQ-039 Run drop: run low during DWELL of 8'h11 -> en_c for 11 completes, IDLE after NEXT, no en_a for 12.
REQ-040 Contention: step pulsed during LOAD_WORD -> ignored; run+step together in IDLE -> run sequence, no extra execution.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the ROM/ALU sequencer and its dwell timer.
package seq_pkg;

  localparam int ADDR_W = 8;
  localparam int DWELL_CNT_W = 26;

  // Sequencer states; explicit encodings keep waveforms stable across builds.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SET_ADDR  = 3'd1,
    S_WAIT_ROM  = 3'd2,
    S_LOAD_WORD = 3'd3,
    S_LOAD_RES  = 3'd4,
    S_DWELL     = 3'd5,
    S_NEXT      = 3'd6
  } state_e;

  // Load strobes for address register (a), ROM word register (b), result register (c).
  typedef struct packed {
    logic en_a;
    logic en_b;
    logic en_c;
  } strobe_t;

endpackage

// File: rtl/dwell_timer.sv
// Down-counter that times how long a result stays on the display.
// 'load' (re)starts the count; 'tc' is high during the last dwell cycle.
module dwell_timer
  import seq_pkg::*;
#(
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic tc
);

  localparam logic [DWELL_CNT_W-1:0] LOAD_VAL = DWELL_CNT_W'(DWELL_CYCLES);
  localparam logic [DWELL_CNT_W-1:0] ONE      = DWELL_CNT_W'(1);

  logic [DWELL_CNT_W-1:0] cnt_q;
  logic [DWELL_CNT_W-1:0] cnt_d;

  // Next count: reload on start, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Loaded with N, the count is 1 in the N-th cycle after load.
  assign tc = (cnt_q == ONE);

endmodule

// File: rtl/rom_alu_sequencer.sv
// Walks a ROM address range, strobing the address/word/result registers
// of the ROM/ALU stage and holding each result for a dwell period.
module rom_alu_sequencer
  import seq_pkg::*;
#(
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              run,
  input  logic              step,
  output logic [ADDR_W-1:0] addr_o,
  output logic              en_a,
  output logic              en_b,
  output logic              en_c,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic              run_mode_q, run_mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  strobe_t           strb_q, strb_d;
  logic              done_q, done_d;
  logic              dwell_tc;

  dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell (
    .clk (clk),
    .rst (rst),
    .load(state_q == S_LOAD_RES),
    .tc  (dwell_tc)
  );

  // FSM transitions, address advance and registered-output decode.
  // A single step advances cur by one without range wrap, so stepping
  // from reset walks 0,1,2,...; the captured range only governs run mode.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    start_d    = start_q;
    end_d      = end_q;
    run_mode_d = run_mode_q;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          start_d    = start_addr;
          end_d      = end_addr;
          cur_d      = start_addr;
          run_mode_d = 1'b1;
          state_d    = S_SET_ADDR;
        end else if (step) begin
          run_mode_d = 1'b0;
          state_d    = S_SET_ADDR;
        end
      end
      S_SET_ADDR:  state_d = S_WAIT_ROM;
      S_WAIT_ROM:  state_d = S_LOAD_WORD;
      S_LOAD_WORD: state_d = S_LOAD_RES;
      S_LOAD_RES:  state_d = S_DWELL;
      S_DWELL: begin
        if (dwell_tc) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (run_mode_q) begin
          cur_d   = (cur_q == end_q) ? start_q : cur_q + 8'd1;
          state_d = run ? S_SET_ADDR : S_IDLE;
        end else begin
          cur_d   = cur_q + 8'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet
    // aligned with the state they belong to.
    strb_d.en_a = (state_d == S_SET_ADDR);
    strb_d.en_b = (state_d == S_LOAD_WORD);
    strb_d.en_c = (state_d == S_LOAD_RES);
    addr_d      = (state_d == S_SET_ADDR) ? cur_d : addr_q;
    done_d      = (state_d == S_NEXT) && run_mode_q && (cur_q == end_q);
  end

  // State and output registers; reset aborts any sequence at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      start_q    <= '0;
      end_q      <= '0;
      run_mode_q <= 1'b0;
      addr_q     <= '0;
      strb_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      start_q    <= start_d;
      end_q      <= end_d;
      run_mode_q <= run_mode_d;
      addr_q     <= addr_d;
      strb_q     <= strb_d;
      done_q     <= done_d;
    end
  end

  assign addr_o = addr_q;
  assign en_a   = strb_q.en_a;
  assign en_b   = strb_q.en_b;
  assign en_c   = strb_q.en_c;
  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;

endmodule

// File: tb/tb_rom_alu_sequencer.sv
// Self-checking bench for rom_alu_sequencer with a short dwell period.
module tb_rom_alu_sequencer;

  localparam int DW  = 4;
  localparam int PER = 4 + DW + 1;  // cycles per executed address

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] start_addr, end_addr;
  logic       run, step;
  logic [7:0] addr_o;
  logic       en_a, en_b, en_c, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rom_alu_sequencer #(.DWELL_CYCLES(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_addr(start_addr),
    .end_addr  (end_addr),
    .run       (run),
    .step      (step),
    .addr_o    (addr_o),
    .en_a      (en_a),
    .en_b      (en_b),
    .en_c      (en_c),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [7:0]  s;
    logic [7:0]  e;
    int          nexec;
    int          drop;
    bit          with_step;
    logic [39:0] exp_addr;  // first address in bits [39:32]
    int          exp_en_a;
    int          exp_done;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, ".en_a"}, int'(en_a), 0);
    chk({nm, ".en_b"}, int'(en_b), 0);
    chk({nm, ".en_c"}, int'(en_c), 0);
    chk({nm, ".busy"}, int'(busy), 0);
    chk({nm, ".done"}, int'(done), 0);
  endtask

  // Start a run-mode sequence from IDLE and check every cycle against a
  // schedule derived from the address list: execution k starts 9*k cycles
  // after entry, with en_a/en_b/en_c at offsets 0/2/3 and done at offset 8
  // for the end address. run is dropped at offset 'drop' of the last one.
  task automatic run_and_check(input logic [7:0] s, input logic [7:0] e,
                               input int nexec, input int drop, input bit with_step,
                               output int n_en_a, output logic [39:0] seen,
                               output int n_done);
    int span, total, k, o, idx;
    logic [7:0] exp_a, last_a;
    span   = ((int'(e) - int'(s) + 256) % 256) + 1;
    total  = nexec * PER;
    n_en_a = 0;
    n_done = 0;
    seen   = '0;
    last_a = s;
    start_addr = s;
    end_addr   = e;
    run  = 1'b1;
    step = with_step;
    for (int cyc = 0; cyc < total + 3; cyc++) begin
      tick();
      step = 1'b0;
      k = cyc / PER;
      o = cyc % PER;
      if (k == nexec - 1 && o == drop) run = 1'b0;
      if (cyc < total) begin
        idx   = k % span;
        exp_a = 8'((int'(s) + idx) % 256);
        last_a = exp_a;
        chk("run.en_a", int'(en_a), int'(o == 0));
        chk("run.en_b", int'(en_b), int'(o == 2));
        chk("run.en_c", int'(en_c), int'(o == 3));
        chk("run.done", int'(done), int'(o == PER - 1 && idx == span - 1));
        chk("run.busy", int'(busy), 1);
        chk("run.addr_o", int'(addr_o), int'(exp_a));
      end else begin
        chk_idle("run.after");
        chk("run.addr_hold", int'(addr_o), int'(last_a));
      end
      if (en_a) begin
        if (n_en_a < 5) seen[39 - 8*n_en_a -: 8] = addr_o;
        n_en_a++;
      end
      if (done) n_done++;
    end
    $display("run s=%02h e=%02h n=%0d drop=%0d step=%0d -> en_a=%0d done=%0d",
             s, e, nexec, drop, with_step, n_en_a, n_done);
  endtask

  // One step execution from IDLE; optionally pulse step again in LOAD_WORD.
  task automatic step_and_check(input logic [7:0] exp_addr, input bit poke);
    step = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      step = (poke && c == 3);
      chk("step.en_a", int'(en_a), int'(c == 1));
      chk("step.en_b", int'(en_b), int'(c == 3));
      chk("step.en_c", int'(en_c), int'(c == 4));
      chk("step.busy", int'(busy), int'(c <= 9));
      if (c == 1) chk("step.addr_o", int'(addr_o), int'(exp_addr));
    end
    $display("step addr=%02h poke=%0d", exp_addr, poke);
  endtask

  vec_t        tv[5];
  int          n_en_a, n_done;
  logic [39:0] seen;

  initial begin
    rst = 1'b1; run = 1'b0; step = 1'b0; start_addr = '0; end_addr = '0;
    tv[0] = '{8'h10, 8'h12, 4, 8, 1'b0, {8'h10, 8'h11, 8'h12, 8'h10, 8'h00}, 4, 1};
    tv[1] = '{8'hFE, 8'h01, 5, 3, 1'b0, {8'hFE, 8'hFF, 8'h00, 8'h01, 8'hFE}, 5, 1};
    tv[2] = '{8'h33, 8'h33, 3, 0, 1'b0, {8'h33, 8'h33, 8'h33, 8'h00, 8'h00}, 3, 3};
    tv[3] = '{8'h10, 8'h12, 2, 5, 1'b0, {8'h10, 8'h11, 8'h00, 8'h00, 8'h00}, 2, 0};
    tv[4] = '{8'h20, 8'h21, 2, 8, 1'b1, {8'h20, 8'h21, 8'h00, 8'h00, 8'h00}, 2, 1};

    // Reset state
    tick(); tick();
    chk_idle("reset");
    chk("reset.addr_o", int'(addr_o), 0);
    rst = 1'b0;
    tick();
    chk_idle("idle");
    $display("reset checked");

    // Step mode from cur=0, then a step poked during LOAD_WORD is ignored
    step_and_check(8'h00, 1'b0);
    step_and_check(8'h01, 1'b1);
    step_and_check(8'h02, 1'b0);

    // Reset during SET_ADDR aborts; rst outranks run
    start_addr = 8'h40; end_addr = 8'h44; run = 1'b1;
    tick();
    chk("abort.en_a", int'(en_a), 1);
    chk("abort.addr_o", int'(addr_o), 32'h40);
    rst = 1'b1;
    tick();
    chk_idle("abort");
    chk("abort.addr_o_rst", int'(addr_o), 0);
    tick();
    chk_idle("abort.hold");
    run = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk_idle("abort.release");
    $display("reset-abort checked");

    // Directed vectors
    for (int i = 0; i < 5; i++) begin
      run_and_check(tv[i].s, tv[i].e, tv[i].nexec, tv[i].drop, tv[i].with_step,
                    n_en_a, seen, n_done);
      chk("vec.n_en_a", n_en_a, tv[i].exp_en_a);
      chk("vec.n_done", n_done, tv[i].exp_done);
      for (int j = 0; j < 5; j++) begin
        if (j < tv[i].exp_en_a)
          chk("vec.addr_seq", int'(seen[39 - 8*j -: 8]), int'(tv[i].exp_addr[39 - 8*j -: 8]));
      end
    end

    // Randomized run sequences checked against the schedule model
    for (int r = 0; r < 10; r++) begin
      logic [7:0] rs, re;
      rs = 8'($urandom_range(0, 255));
      re = rs + 8'($urandom_range(0, 4));
      run_and_check(rs, re, int'($urandom_range(1, 6)), int'($urandom_range(0, 8)),
                    1'($urandom_range(0, 1)), n_en_a, seen, n_done);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
